// File: rtl/mcu16c_pkg.sv
// Shared MCU16C definitions used by PC14, the program memory and their benches.
package mcu16c_pkg;

    localparam logic [15:0] NOP_WORD = 16'hE200;

    typedef enum logic [1:0] {
        LD_ST_HOLD = 2'd0,
        LD_ST_RUN  = 2'd1,
        LD_ST_HI   = 2'd2,
        LD_ST_LO   = 2'd3
    } ld_state_e;

endpackage

// File: rtl/pmem_ram.sv
// Single-clock program RAM: one write port and one registered read port with
// read enable, written so synthesis can map it onto block RAM.
module pmem_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem_q [2**AW];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pmem14_loader.sv
// PC14 program memory with a byte-stream loader that holds the CPU in reset while
// it rewrites the program. Define PMEM_CHECKSUM_EN to build the ld_sum accumulator.
module pmem14_loader
    import mcu16c_pkg::*;
#(
    parameter int          AW       = 14,
    parameter logic [15:0] NOP      = NOP_WORD,
    parameter int          RST_HOLD = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] paddr,
    input  logic          ce,
    output logic [15:0]   pdata,
    output logic          cpu_rst,
    input  logic          ld_en,
    input  logic [7:0]    ld_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    output logic [AW:0]   ld_count,
    output logic          ld_ovf,
    output logic [15:0]   ld_sum
);

    localparam int          HW        = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
    localparam logic [AW:0] COUNT_MAX = {1'b1, {AW{1'b0}}};

    ld_state_e     state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    hi_q, hi_d;
    logic          nop_sel_q, nop_sel_d;
    logic          accept;
    logic          start;
    logic          we;
    logic [15:0]   wdata;
    logic [15:0]   ram_rdata;

    assign ld_ready = (state_q == LD_ST_HI) || (state_q == LD_ST_LO);
    assign cpu_rst  = (state_q != LD_ST_RUN);
    assign accept   = ld_valid & ld_ready & ld_en;
    assign wdata    = {hi_q, ld_data};

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        waddr_d = waddr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        hi_d    = hi_q;
        start   = 1'b0;
        we      = 1'b0;
        case (state_q)
            LD_ST_HOLD: begin
                if (ld_en) begin
                    start = 1'b1;
                end else if (hold_q == '0) begin
                    state_d = LD_ST_RUN;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            LD_ST_RUN: begin
                start = ld_en;
            end
            LD_ST_HI, LD_ST_LO: begin
                // Dropping ld_en abandons any unpaired high byte without writing.
                if (!ld_en) begin
                    state_d = LD_ST_HOLD;
                    hold_d  = HW'(RST_HOLD);
                end else if (accept && state_q == LD_ST_HI) begin
                    hi_d    = ld_data;
                    state_d = LD_ST_LO;
                end else if (accept) begin
                    we      = 1'b1;
                    waddr_d = waddr_q + 1'b1;
                    ovf_d   = ovf_q | (waddr_q == '1);
                    count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
                    state_d = LD_ST_HI;
                end
            end
            default: state_d = LD_ST_HOLD;
        endcase
        if (start) begin
            state_d = LD_ST_HI;
            waddr_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_comb begin
        nop_sel_d = nop_sel_q;
        if (cpu_rst) begin
            nop_sel_d = 1'b1;
        end else if (ce) begin
            nop_sel_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LD_ST_HOLD;
            hold_q    <= HW'(RST_HOLD);
            waddr_q   <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            hi_q      <= '0;
            nop_sel_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            waddr_q   <= waddr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            hi_q      <= hi_d;
            nop_sel_q <= nop_sel_d;
        end
    end

`ifdef PMEM_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start) begin
            sum_d = '0;
        end else if (we) begin
            sum_d = sum_q + wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign ld_sum = sum_q;
`else
    assign ld_sum = '0;
`endif

    // Writes only happen while the CPU is held, so the read port never needs a bypass.
    pmem_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr_q),
        .wdata (wdata),
        .re    (ce & ~cpu_rst),
        .raddr (paddr),
        .rdata (ram_rdata)
    );

    assign pdata    = nop_sel_q ? NOP : ram_rdata;
    assign ld_count = count_q;
    assign ld_ovf   = ovf_q;

endmodule

// File: doc/pmem14_loader.md
# pmem14_loader

Program memory for the MCU16C program control unit (PC14). Holds 2^AW 16-bit instruction words and returns `pdata` one clock after `paddr`. Includes a byte-stream loader that holds the CPU in reset, writes a new program from address 0, then releases the CPU. Sits directly upstream of PC14: it consumes PC14's `paddr`/`ce` and produces `pdata`.

## Interface
- `AW`, 14, address width; depth is 2^AW words.
- `NOP`, 16'hE200, word driven on `pdata` while the CPU is held in reset (OR R0,R0).
- `RST_HOLD`, 2, cycles `cpu_rst` stays high after loading ends or after `rst`.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `paddr`  in  AW  instruction fetch address from PC14.
- `ce`  in  1  fetch clock enable; same signal as PC14 `ce`.
- `pdata`  out  16  registered instruction word to PC14.
- `cpu_rst`  out  1  drives PC14 `rst`; high = CPU held.
- `ld_en`  in  1  loader session request; level-sensitive.
- `ld_data`  in  8  load byte; high byte first, then low byte.
- `ld_valid`  in  1  `ld_data` valid.
- `ld_ready`  out  1  loader can accept a byte.
- `ld_count`  out  AW+1  words written in the current or last session.
- `ld_ovf`  out  1  sticky flag: address wrapped during this session.
- `ld_sum`  out  16  checksum of loaded words (see Configuration).

## Operation
- States: HOLD, RUN, LD_HI, LD_LO.
- HOLD: `cpu_rst`=1. Hold counter decrements each cycle. At 0, go to RUN. If `ld_en`=1, go to LD_HI.
- RUN: `cpu_rst`=0. If `ld_en`=1, go to LD_HI and set `cpu_rst`=1 on the same edge.
- Entry to LD_HI from HOLD or RUN:
  - write address := 0
  - `ld_count` := 0
  - `ld_ovf` := 0
  - `ld_sum` := 0
- A byte is accepted when `ld_valid & ld_ready & ld_en`. `ld_ready` = 1 only in LD_HI and LD_LO.
- LD_HI: on accept, latch the high byte and go to LD_LO.
- LD_LO: on accept:
  - write mem[waddr] = {hi, ld_data}
  - waddr += 1, modulo 2^AW; on wrap from 2^AW−1 to 0, set `ld_ovf`
  - `ld_count` += 1, saturating at 2^AW
  - go to LD_HI
- `ld_en` low in LD_HI or LD_LO:
  - go to HOLD with hold counter = RST_HOLD
  - a latched but unpaired high byte is discarded and memory is not written
- Fetch port:
  - `cpu_rst`=1 → `pdata` <= NOP.
  - `cpu_rst`=0 and `ce`=1 → `pdata` <= mem[`paddr`].
  - `ce`=0 → `pdata` holds its value.
- Memory contents are not cleared by `rst` or by a load session. Unwritten locations keep prior values; initial contents are 0.

## Timing
- Reset values:
  - state HOLD, hold counter RST_HOLD
  - `cpu_rst`=1, `pdata`=NOP, `ld_ready`=0
  - `ld_count`=0, `ld_ovf`=0, `ld_sum`=0
- `rst` mid-load aborts the session: no further writes, counters cleared, HOLD entered.
- After `rst` deasserts, `cpu_rst` stays high for RST_HOLD+1 edges, counting the reset edge. The first fetch from the released CPU is presented after that.
- `ld_en` rising: `ld_ready` goes high the next cycle. Bytes presented before that are ignored.
- Write latency: a word is in memory at the edge that accepts its low byte. It is readable on the next fetch.
- Read latency: 1 cycle, `paddr` edge N → `pdata` edge N+1. No bypass of same-cycle writes is needed because the CPU is held while writing.
- Throughput: 1 byte per cycle when `ld_valid` is held high. Gaps in `ld_valid` are allowed in either state.

## Configuration
- `PMEM_CHECKSUM_EN` defined:
  - `ld_sum` accumulates the 16-bit modulo-2^16 sum of every word written in the session, updated on the write edge.
- `PMEM_CHECKSUM_EN` not defined:
  - `ld_sum` is tied to 0 and no adder is built.
- The port exists in both cases.

## Structure
- Shared package `mcu16c_pkg` holds the NOP word constant (16'hE200) and the loader state enum. PC14 and its bench share that package.
- One sub-module, `pmem_ram`: single-clock, 1 write port + 1 registered read port, inferable as block RAM. The FSM, counters and checksum stay in the top module.

## Test plan
- Reset: hold `rst` 1 cycle, `ld_en`=0 → `cpu_rst`=1 for 3 edges, then 0. `pdata`=16'hE200 throughout the hold.
- Load: `ld_en`=1, bytes 40,10,01,11, then `ld_en`=0:
  - `ld_count`=2, `ld_ovf`=0
  - after release, `paddr`=0 → `pdata`=16'h4010 next cycle; `paddr`=1 → 16'h0111
  - with `PMEM_CHECKSUM_EN`, `ld_sum`=16'h4121
- Partial word: bytes 50,00,62, then `ld_en`=0 → `ld_count`=1, mem[0]=16'h5000, mem[1] unchanged.
- Byte gaps: `ld_valid` toggled 1,0,0,1,0,1,1 carrying E2,00,68,00 → mem[0]=16'hE200, mem[1]=16'h6800.
- `ce`=0 for 3 cycles while `paddr` changes → `pdata` is held. `ce`=1 → the new word appears one cycle later.
- Wrap with AW=2: load 5 words 0001..0005 → `ld_ovf`=1, `ld_count`=4 (saturated), mem[0]=16'h0005. Asserting `rst` mid-byte aborts the session: `ld_count`=0.
